// File: rtl/div_pkg.sv
// +----------------------------------------------------------------------+
// | div_pkg: shared width default, FSM encoding and counter sizing.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_fixup = 2'd2;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

`default_nettype wire

// File: rtl/trial_subtractor.sv
// +----------------------------------------------------------------------+
// | trial_subtractor: (WIDTH+1)-bit subtract with non-negative flag.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module trial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] minuend,
  input  logic [WIDTH:0] subtrahend,
  output logic [WIDTH:0] difference,
  output logic           non_negative
);

  assign difference   = minuend - subtrahend;
  assign non_negative = ~difference[WIDTH];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// +----------------------------------------------------------------------+
// | seq_divider: restoring radix-2 divider, signed/unsigned, 1 bit/cycle.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_dividend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_non_neg;

  // Magnitudes: -2^(WIDTH-1) maps onto itself, which is correct as unsigned.
  assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};

  trial_subtractor #(
    .WIDTH (WIDTH)
  ) u_trial_subtractor (
    .minuend      (w_shift),
    .subtrahend   ({1'b0, r_dvs}),
    .difference   (w_diff),
    .non_negative (w_non_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_idle;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_dividend    <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz         <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state    <= c_st_run;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_dvd_mag;
            r_dvs      <= w_dvs_mag;
            r_dividend <= dividend;
            r_neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r    <= is_signed & dividend[WIDTH-1];
            r_dbz      <= (divisor == '0);
          end
        end
        c_st_run: begin
          r_rem <= w_non_neg ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_non_neg};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= c_st_fixup;
          end
        end
        c_st_fixup: begin
          r_state       <= c_st_idle;
          r_done        <= 1'b1;
          r_div_by_zero <= r_dbz;
          if (r_dbz) begin
            r_quotient  <= '1;
            r_remainder <= r_dividend;
          end else begin
            r_quotient  <= r_neg_q ? -r_quo : r_quo;
            r_remainder <= r_neg_r ? -r_rem : r_rem;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign busy        = (r_state != c_st_idle);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request a division; sampled only when not busy.
REQ-005 Port: is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 Port: dividend  input  WIDTH  numerator; sampled with start.
REQ-007 Port: divisor  input  WIDTH  denominator; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  single-cycle pulse; results valid.
REQ-010 Port: quotient  output  WIDTH  result, destined for LO.
REQ-011 Port: remainder  output  WIDTH  result, destined for HI.
REQ-012 Port: div_by_zero  output  1  set with done when the sampled divisor was 0.

Function
REQ-013 FSM states IDLE, RUN, FIXUP; IDLE->RUN on start; RUN->FIXUP after exactly WIDTH iterations; FIXUP->IDLE unconditionally.
REQ-014 Start accepted at rising edge k while in IDLE; busy high from edge k until edge k+WIDTH+1, otherwise low.
REQ-015 done asserted high for exactly one cycle, following edge k+WIDTH+1 (latency 33 cycles for WIDTH=32); outputs updated at that same edge.
REQ-016 start while busy ignored: no restart, no operand capture.
REQ-017 start during the done cycle accepted (back-to-back operations).
REQ-018 RUN: restoring algorithm, one quotient bit per cycle, MSB first; trial subtract of (WIDTH+1)-bit partial remainder minus divisor magnitude; non-negative result kept, quotient bit 1; otherwise restore, quotient bit 0.
REQ-019 Signed mode: operands converted to magnitudes at capture; in FIXUP, quotient negated if operand signs differ, remainder takes sign of dividend (truncating division).
REQ-020 Signed overflow (dividend = 2^(WIDTH-1) negative, divisor = -1): quotient = 0x80000000, remainder = 0, div_by_zero = 0.
REQ-021 Divisor = 0 (either mode): quotient = all ones, remainder = dividend as sampled, div_by_zero = 1, same latency as normal.
REQ-022 quotient, remainder, div_by_zero hold value after done until the next done; unaffected by start acceptance or inputs.
REQ-023 Operands captured internally at start; input changes during RUN have no effect.

Reset
REQ-024 rst_n low forces state IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, internal registers 0, independent of clk.
REQ-025 Reset mid-operation abandons the division; no done pulse; first start after rst_n deasserts behaves per REQ-014.

Structure
REQ-026 Shared package div_pkg holds WIDTH default, FSM state encoding, and the iteration-counter width ($clog2(WIDTH)+1).
REQ-027 One sub-module trial_subtractor: combinational (WIDTH+1)-bit subtract returning difference and non-negative flag; instantiated once.

Verification
REQ-028 DIVU 100 / 7 -> quotient 14, remainder 2, div_by_zero 0, done exactly 33 cycles after start edge, busy high 33 cycles.
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1.
REQ-030 DIVU 0x00001234 / 0 -> quotient 0xFFFFFFFF, remainder 0x00001234, div_by_zero 1.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-032 start 100/7, second start (50/5) at cycle 5 -> ignored, result 14/2; start 50/5 in done cycle -> result 10/0 33 cycles later.
REQ-033 rst_n low at cycle 10 of a run -> busy 0, done 0, outputs 0 immediately; no done pulse; next op 9/3 -> 3/0.
